l2_arbiter: RTL and testbench

L2_ARBITER -- requirements
Module: l2_arbiter

---
 rtl/l2_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_l2_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: four-core round-robin front end for a shared L2.
// One request is in flight at a time. The flow is:
//   1. pick a winner,
//   2. issue the request to L2 and hold it until l2_ready,
//   3. for a write, optionally broadcast an update to the other sharers,
//   4. return a one-cycle grant pulse together with the response data.
// Optional feature: define L2ARB_SNOOP_EN to enable the write-snoop
// broadcast. Without it, writes complete straight after the L2 handshake
// and the snoop outputs are tied to zero.
module l2_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // core side
  input  logic [3:0]          req,
  input  logic [7:0]          req_mode,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_wdata,
  output logic [3:0]          gnt,
  output logic [DATA_W-1:0]   rsp_data,
  // L2 side
  output logic                l2_valid,
  output logic [1:0]          l2_mode,
  output logic [ADDR_W-1:0]   l2_addr,
  output logic [DATA_W-1:0]   l2_wdata,
  output logic [1:0]          l2_proin,
  input  logic                l2_ready,
  input  logic [DATA_W-1:0]   l2_rdata,
  input  logic [3:0]          l2_sharers,
  // coherency side
  output logic [3:0]          snoop_valid,
  output logic [ADDR_W-1:0]   snoop_addr,
  output logic [DATA_W-1:0]   snoop_data
);

  localparam logic [1:0] MODE_RD = 2'b00;
  localparam logic [1:0] MODE_WR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SNOOP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_winner_q, last_winner_d;
  // Latched transaction. These registers drive the l2_* outputs directly,
  // so they stay stable for as long as ISSUE lasts.
  logic [1:0]        id_q, id_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;

  // Per-core views of the packed request buses.
  logic [1:0]        core_mode  [4];
  logic [ADDR_W-1:0] core_addr  [4];
  logic [DATA_W-1:0] core_wdata [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_core
      assign core_mode[gi]  = req_mode[2*gi +: 2];
      assign core_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign core_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic       win_found;
  logic [1:0] win_id;
  logic       is_write;
  logic [3:0] id_onehot;

  assign is_write  = (mode_q == MODE_WR);
  assign id_onehot = 4'b0001 << id_q;

  // Round-robin search. It starts one past the last winner and wraps mod 4,
  // so the last winner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_winner_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && req[2'(last_winner_q + 2'(k))]) begin
        win_found = 1'b1;
        win_id    = 2'(last_winner_q + 2'(k));
      end
    end
  end

`ifdef L2ARB_SNOOP_EN
  logic [3:0]        snoop_valid_q, snoop_valid_d;
  logic [ADDR_W-1:0] snoop_addr_q, snoop_addr_d;
  logic [DATA_W-1:0] snoop_data_q, snoop_data_d;
`else
  // Sharer information has no consumer when snooping is compiled out.
  logic unused_sharers;
  assign unused_sharers = ^l2_sharers;
`endif

  // Next-state and next-output logic. Strobes default low so that each one
  // lives for exactly one cycle.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    id_d          = id_q;
    mode_d        = mode_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    valid_d       = 1'b0;
    gnt_d         = 4'b0000;
    rsp_d         = rsp_q;
`ifdef L2ARB_SNOOP_EN
    snoop_valid_d = 4'b0000;
    snoop_addr_d  = '0;
    snoop_data_d  = '0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          // Capture the winner's request. Later changes on the core
          // buses cannot disturb the transaction in flight.
          id_d    = win_id;
          mode_d  = (core_mode[win_id] == MODE_WR) ? MODE_WR : MODE_RD;
          addr_d  = core_addr[win_id];
          wdata_d = core_wdata[win_id];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        valid_d = 1'b1;
        if (l2_ready) begin
          valid_d = 1'b0;
          if (is_write) begin
            rsp_d = wdata_q;
`ifdef L2ARB_SNOOP_EN
            // The writer already has the new data, so its own sharer bit
            // is masked out of the update broadcast.
            snoop_valid_d = l2_sharers & ~id_onehot;
            snoop_addr_d  = addr_q;
            snoop_data_d  = wdata_q;
            state_d       = SNOOP;
`else
            gnt_d   = id_onehot;
            state_d = DONE;
`endif
          end else begin
            rsp_d   = l2_rdata;
            gnt_d   = id_onehot;
            state_d = DONE;
          end
        end
      end
      SNOOP: begin
        // The broadcast cycle is spent even when the sharer mask is empty.
        gnt_d   = id_onehot;
        state_d = DONE;
      end
      DONE: begin
        last_winner_d = id_q;
        state_d       = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_winner_q <= 2'd3;
      id_q          <= 2'd0;
      mode_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      valid_q       <= 1'b0;
      gnt_q         <= 4'b0000;
      rsp_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      id_q          <= id_d;
      mode_q        <= mode_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      valid_q       <= valid_d;
      gnt_q         <= gnt_d;
      rsp_q         <= rsp_d;
    end
  end

`ifdef L2ARB_SNOOP_EN
  // Snoop broadcast registers; the mask is loaded only when entering SNOOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_valid_q <= 4'b0000;
      snoop_addr_q  <= '0;
      snoop_data_q  <= '0;
    end else begin
      snoop_valid_q <= snoop_valid_d;
      snoop_addr_q  <= snoop_addr_d;
      snoop_data_q  <= snoop_data_d;
    end
  end

  assign snoop_valid = snoop_valid_q;
  assign snoop_addr  = snoop_addr_q;
  assign snoop_data  = snoop_data_q;
`else
  assign snoop_valid = 4'b0000;
  assign snoop_addr  = '0;
  assign snoop_data  = '0;
`endif

  assign gnt      = gnt_q;
  assign rsp_data = rsp_q;
  assign l2_valid = valid_q;
  assign l2_mode  = mode_q;
  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;
  assign l2_proin = id_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Testbench for l2_arbiter. Directed scenarios are followed by randomized
// transactions. Every transaction is predicted at transaction level: the
// winner, the captured fields, the latency, the sharer mask and the response.
module tb_l2_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
`ifdef L2ARB_SNOOP_EN
  localparam bit SNOOP_EN = 1'b1;
`else
  localparam bit SNOOP_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [3:0]          req = '0;
  logic [7:0]          req_mode = '0;
  logic [4*ADDR_W-1:0] req_addr = '0;
  logic [4*DATA_W-1:0] req_wdata = '0;
  logic [3:0]          gnt;
  logic [DATA_W-1:0]   rsp_data;
  logic                l2_valid;
  logic [1:0]          l2_mode;
  logic [ADDR_W-1:0]   l2_addr;
  logic [DATA_W-1:0]   l2_wdata;
  logic [1:0]          l2_proin;
  logic                l2_ready = 1'b0;
  logic [DATA_W-1:0]   l2_rdata = '0;
  logic [3:0]          l2_sharers = '0;
  logic [3:0]          snoop_valid;
  logic [ADDR_W-1:0]   snoop_addr;
  logic [DATA_W-1:0]   snoop_data;

  int total = 0;
  int bad = 0;
  int last_model = 3;
  logic [3:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  l2_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_data(rsp_data),
    .l2_valid(l2_valid), .l2_mode(l2_mode), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_proin(l2_proin), .l2_ready(l2_ready), .l2_rdata(l2_rdata), .l2_sharers(l2_sharers),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_data(snoop_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration rule: first requester after the last winner, mod 4.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic scramble_fields();
    for (int c = 0; c < 4; c++) begin
      req_mode[2*c +: 2]           = 2'($urandom_range(0, 3));
      req_addr[c*ADDR_W +: ADDR_W] = $urandom;
      req_wdata[c*DATA_W +: DATA_W] = {$urandom, $urandom};
    end
  endtask

  // Runs one transaction. The DUT must be idle and req non-zero; the next
  // rising edge is the sampling edge. w is the number of ISSUE wait cycles.
  task automatic do_txn(input int w, input logic [DATA_W-1:0] rd, input logic [3:0] sh,
                        input bit keep, input logic [3:0] new_reqs,
                        output logic [3:0] gnt_seen);
    int id;
    int exp_n;
    bit is_w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [3:0] mask;
    logic [3:0] exp_sv;
    logic [3:0] exp_gnt;
    gnt_seen = '0;
    id = rr_pick(req, last_model);
    if (id < 0) begin
      $display("FAIL do_txn called with no request pending");
      $fatal(1, "bench sequencing error");
    end
    is_w  = (req_mode[2*id +: 2] == 2'b11);
    a     = req_addr[id*ADDR_W +: ADDR_W];
    d     = req_wdata[id*DATA_W +: DATA_W];
    mask  = sh & ~(4'b0001 << id);
    exp_n = w + 2 + ((is_w && SNOOP_EN) ? 1 : 0);
    @(posedge clk);
    #1;
    // After capture the core buses change freely and more cores may request.
    scramble_fields();
    req        = req | new_reqs;
    l2_ready   = (w == 0);
    l2_rdata   = rd;
    l2_sharers = sh;
    for (int n = 1; n <= exp_n; n++) begin
      @(negedge clk);
      if (n <= w + 1)
        check_eq("l2_req", {28'd0, l2_valid, l2_mode == 2'b11, l2_proin, l2_addr, l2_wdata},
                 {28'd0, 1'b1, is_w, 2'(id), a, d});
      else
        check_eq("l2_valid_drop", l2_valid, 0);
      exp_sv = (SNOOP_EN && is_w && n == w + 2) ? mask : 4'd0;
      check_eq("snoop_valid", snoop_valid, exp_sv);
      if (exp_sv != 4'd0 || !SNOOP_EN)
        check_eq("snoop_payload", {snoop_addr, snoop_data}, SNOOP_EN ? {a, d} : 96'd0);
      exp_gnt = (n == exp_n) ? (4'b0001 << id) : 4'd0;
      check_eq("gnt", gnt, exp_gnt);
      if (n == exp_n) begin
        gnt_seen = gnt;
        check_eq("rsp_data", rsp_data, is_w ? d : rd);
      end
      if (n == w + 1 && w > 0) l2_ready = 1'b1;
      if (n == w + 2) begin
        // Post-handshake L2 activity must not leak into the response.
        l2_ready   = 1'b0;
        l2_rdata   = {$urandom, $urandom};
        l2_sharers = 4'($urandom);
      end
    end
    @(posedge clk);
    #1;
    last_model = id;
    req[id]    = keep;
    @(negedge clk);
    check_eq("idle_after_done", {gnt, l2_valid, snoop_valid}, 0);
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, then
  // releases on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ctl", {gnt, l2_valid, l2_mode, l2_proin, snoop_valid}, 0);
    check_eq("rst_rsp", rsp_data, 0);
    check_eq("rst_l2", {l2_addr, l2_wdata}, 0);
    check_eq("rst_snoop", {snoop_addr, snoop_data}, 0);
    l2_ready = 1'b0;
    req      = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold", {gnt, l2_valid, snoop_valid}, 0);
    rst_n      = 1'b1;
    last_model = 3;
  endtask

  initial begin
    logic [3:0] g;
    scramble_fields();
    apply_reset();

    // Directed read by core 0.
    req = 4'b0001;
    req_mode[1:0] = 2'b00;
    req_addr[ADDR_W-1:0] = 32'h0000_1111;
    do_txn(0, 64'h0000_0000_0000_000f, 4'b0000, 1'b0, 4'b0000, g);
    check_eq("read_gnt", g, 4'b0001);

    // Directed write by core 0 with sharers 1011.
    req = 4'b0001;
    req_mode[1:0] = 2'b11;
    req_addr[ADDR_W-1:0] = 32'h1001_0010;
    req_wdata[DATA_W-1:0] = 64'h0000_0000_0000_000e;
    do_txn(0, {$urandom, $urandom}, 4'b1011, 1'b0, 4'b0000, g);
    check_eq("write_gnt", g, 4'b0001);

    // All cores requesting continuously from reset.
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_txn($urandom_range(0, 2), {$urandom, $urandom}, 4'($urandom), 1'b1, 4'b0000, g);
      check_eq("fair_order", g, fair_exp[i]);
    end

    // Back-pressure on a core 2 read while the other cores start requesting.
    req = 4'b0100;
    req_mode[5:4] = 2'b00;
    do_txn(5, {$urandom, $urandom}, 4'($urandom), 1'b0, 4'b1011, g);
    check_eq("bp_gnt", g, 4'b0100);

    // Reset while a core 1 write is waiting in ISSUE.
    req = 4'b0010;
    req_mode[3:2] = 2'b11;
    l2_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("issue_before_rst", {l2_valid, l2_proin}, {1'b1, 2'd1});
    apply_reset();
    req = 4'b1111;
    do_txn(0, {$urandom, $urandom}, 4'($urandom), 1'b1, 4'b0000, g);
    check_eq("post_rst_first", g, 4'b0001);

    // Randomized traffic.
    for (int t = 0; t < 120; t++) begin
      if (req == 4'b0000) begin
        @(posedge clk);
        @(negedge clk);
        check_eq("idle_quiet", {gnt, l2_valid, snoop_valid}, 0);
        req = 4'($urandom_range(1, 15));
      end
      do_txn($urandom_range(0, 3), {$urandom, $urandom}, 4'($urandom),
             1'($urandom_range(0, 1)), 4'($urandom) & 4'($urandom), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
